// File: rtl/ring_cntr_gen.sv
// ring_cntr_gen: run-time selectable one-hot ring / Johnson counter.
// The pattern register and a binary step index advance together, so q
// always equals the decoded pattern of idx. A registered terminal-count
// pulse marks each wrap of the sequence. A registered error pulse flags a
// load whose index lies outside the active period.
module ring_cntr_gen #(
   parameter int N  = 4,
   parameter int IW = $clog2(2*N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_en,
   input  logic          i_dir,
   input  logic          i_mode,
   input  logic          i_load,
   input  logic [IW-1:0] i_load_idx,
   output logic [N-1:0]  o_q,
   output logic [IW-1:0] o_idx,
   output logic          o_tc,
   output logic          o_err
);

   // Last legal index for each mode (period minus one).
   localparam logic [IW-1:0] RING_LAST = IW'(N-1);
   localparam logic [IW-1:0] JOHN_LAST = IW'(2*N-1);

   logic [N-1:0]  r_q;
   logic [IW-1:0] r_idx;
   logic          r_tc;
   logic          r_err;
   logic          r_mode_q;

   logic [N-1:0]  w_q_nxt;
   logic [IW-1:0] w_idx_nxt;
   logic          w_tc_nxt;
   logic          w_err_nxt;
   logic          w_mode_nxt;
   logic [IW-1:0] w_last;

   // Decoded pattern for step index k. Ring: a single bit at (N-k) mod N.
   // Johnson: the top k bits are set for k <= N; beyond that the set region
   // shrinks to the low 2N-k bits.
   function automatic logic [N-1:0] f_pattern(input logic m, input logic [IW-1:0] k);
      logic [N-1:0] p;
      int           kk;
      p  = '0;
      kk = int'(k);
      for (int b = 0; b < N; b++) begin
         if (!m)
            p[b] = (kk == 0) ? (b == 0) : (b == N - kk);
         else if (kk <= N)
            p[b] = (b >= N - kk);
         else
            p[b] = (b < 2*N - kk);
      end
      return p;
   endfunction

   assign w_last = r_mode_q ? JOHN_LAST : RING_LAST;

   // Next-state selection: mode change beats load, load beats step, else hold.
   always_comb begin
      w_q_nxt    = r_q;
      w_idx_nxt  = r_idx;
      w_tc_nxt   = 1'b0;
      w_err_nxt  = 1'b0;
      w_mode_nxt = r_mode_q;
      if (i_mode != r_mode_q) begin
         // Restart from the new mode's seed; any load or step is dropped.
         w_mode_nxt = i_mode;
         w_q_nxt    = f_pattern(i_mode, '0);
         w_idx_nxt  = '0;
      end else if (i_load) begin
         if (i_load_idx <= w_last) begin
            w_q_nxt   = f_pattern(r_mode_q, i_load_idx);
            w_idx_nxt = i_load_idx;
         end else begin
            w_err_nxt = 1'b1;
         end
      end else if (i_en) begin
         // The feedback bit is inverted only in Johnson mode.
         if (!i_dir) begin
            w_q_nxt = {r_q[0] ^ r_mode_q, r_q[N-1:1]};
            if (r_idx == w_last) begin
               w_idx_nxt = '0;
               w_tc_nxt  = 1'b1;
            end else begin
               w_idx_nxt = r_idx + IW'(1);
            end
         end else begin
            w_q_nxt = {r_q[N-2:0], r_q[N-1] ^ r_mode_q};
            if (r_idx == '0) begin
               w_idx_nxt = w_last;
               w_tc_nxt  = 1'b1;
            end else begin
               w_idx_nxt = r_idx - IW'(1);
            end
         end
      end
   end

   // State register with synchronous active-low reset to the sampled mode's seed.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q      <= f_pattern(i_mode, '0);
         r_idx    <= '0;
         r_tc     <= 1'b0;
         r_err    <= 1'b0;
         r_mode_q <= i_mode;
      end else begin
         r_q      <= w_q_nxt;
         r_idx    <= w_idx_nxt;
         r_tc     <= w_tc_nxt;
         r_err    <= w_err_nxt;
         r_mode_q <= w_mode_nxt;
      end
   end

   assign o_q   = r_q;
   assign o_idx = r_idx;
   assign o_tc  = r_tc;
   assign o_err = r_err;

endmodule
